// File: rtl/btn_pkg.sv
// Shared types and default constants for the button event decoder slice.
// Optional auto-repeat is enabled by defining BTN_REPEAT_EN.
package btn_pkg;

   localparam int unsigned LONG_TICKS_DEF   = 4;
   localparam int unsigned REPEAT_TICKS_DEF = 2;
   localparam int unsigned CNT_W_DEF        = 16;

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      IDLE  = 2'd1,
      PRESS = 2'd2,
      LONG  = 2'd3
   } btn_state_e;

   // Plain-vector state codes for the FSM register.
   localparam logic [1:0] ST_ARM   = ARM;
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_PRESS = PRESS;
   localparam logic [1:0] ST_LONG  = LONG;

endpackage

// File: rtl/btn_tick_counter.sv
// Tick counter with clear, increment enable and an equal-to-limit flag.
module btn_tick_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             at_limit_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_c = (cnt_q == limit);

endmodule

// File: rtl/btn_event_decoder.sv
// Turns the debounced button level into one-clock press/release/short/long
// event pulses; auto-repeat (repeat_o) is present only with BTN_REPEAT_EN.
module btn_event_decoder
   import btn_pkg::*;
#(
   parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
   parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic btn_db,
   output logic press_o,
   output logic release_o,
   output logic short_o,
   output logic long_o,
   output logic held_o
`ifdef BTN_REPEAT_EN
   ,
   output logic repeat_o
`endif
);

   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_TICKS - 1);
`endif

   logic [1:0]       state_q, state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             held_q, held_d;
   logic             cnt_clr, cnt_inc;
   logic             cnt_at_lim;
   logic [CNT_W-1:0] cnt_limit;
`ifdef BTN_REPEAT_EN
   logic             repeat_q, repeat_d;
`endif

   // One counter serves both thresholds; the limit follows the state.
`ifdef BTN_REPEAT_EN
   assign cnt_limit = (state_q == ST_LONG) ? REP_LIM : LONG_LIM;
`else
   assign cnt_limit = LONG_LIM;
`endif

   btn_tick_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr),
      .inc        (cnt_inc),
      .limit      (cnt_limit),
      .at_limit_c (cnt_at_lim)
   );

   // Next state, counter control and pulse decode; release beats any threshold.
   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_d  = 1'b0;
`endif
      if (tick_en) begin
         case (state_q)
            ST_ARM: begin
               if (!btn_db) begin
                  state_d = ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (btn_db) begin
                  state_d = ST_PRESS;
                  cnt_clr = 1'b1;
                  press_d = 1'b1;
               end
            end
            ST_PRESS: begin
               if (!btn_db) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
                  short_d   = 1'b1;
               end else if (cnt_at_lim) begin
                  state_d = ST_LONG;
                  cnt_clr = 1'b1;
                  long_d  = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            ST_LONG: begin
               if (!btn_db) begin
                  state_d   = ST_IDLE;
                  release_d = 1'b1;
               end
`ifdef BTN_REPEAT_EN
               else if (cnt_at_lim) begin
                  cnt_clr  = 1'b1;
                  repeat_d = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
`endif
            end
            default: begin
               state_d = ST_ARM;
            end
         endcase
      end
      held_d = (state_d == ST_PRESS) || (state_d == ST_LONG);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ARM;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         long_q    <= long_d;
         held_q    <= held_d;
`ifdef BTN_REPEAT_EN
         repeat_q  <= repeat_d;
`endif
      end
   end

   assign press_o   = press_q;
   assign release_o = release_q;
   assign short_o   = short_q;
   assign long_o    = long_q;
   assign held_o    = held_q;
`ifdef BTN_REPEAT_EN
   assign repeat_o  = repeat_q;
`endif

`ifndef SYNTHESIS
   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   // Out-of-range thresholds would let the counter wrap before matching.
   always @(posedge clk) begin
      assert (64'(LONG_TICKS) >= 64'd2 && 64'(LONG_TICKS) <= CNT_MAX)
         else $error("btn_event_decoder: LONG_TICKS out of range");
      assert (64'(REPEAT_TICKS) >= 64'd1 && 64'(REPEAT_TICKS) <= CNT_MAX)
         else $error("btn_event_decoder: REPEAT_TICKS out of range");
   end
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed vector bench for btn_event_decoder (LONG_TICKS=4, REPEAT_TICKS=2).
// Repeat expectations are compared only when BTN_REPEAT_EN is defined.
module tb_btn_event_decoder;

   logic clk = 1'b0;
   logic rst;
   logic tick_en;
   logic btn_db;
   logic press_o, release_o, short_o, long_o, held_o;
   logic repeat_w;
`ifdef BTN_REPEAT_EN
   logic repeat_o;
   assign repeat_w = repeat_o;
`else
   assign repeat_w = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;

   btn_event_decoder #(
      .LONG_TICKS   (4),
      .REPEAT_TICKS (2),
      .CNT_W        (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_en   (tick_en),
      .btn_db    (btn_db),
      .press_o   (press_o),
      .release_o (release_o),
      .short_o   (short_o),
      .long_o    (long_o),
      .held_o    (held_o)
`ifdef BTN_REPEAT_EN
      ,
      .repeat_o  (repeat_o)
`endif
   );

   always #5 clk = ~clk;

   // exp bits: {press, release, short, long, repeat, held}
   typedef struct {
      logic       rst;
      logic       te;
      logic       btn;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic te, input logic b, input logic [5:0] e);
      vec_t v;
      v.rst = r; v.te = te; v.btn = b; v.exp = e;
      vecs.push_back(v);
   endtask

   // Apply inputs, take one rising edge, settle before sampling.
   task automatic step(input logic r, input logic te, input logic b);
      rst = r; tick_en = te; btn_db = b;
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   logic [5:0] act, mask;
   int press_n, release_n, short_n, long_n, repeat_n, held_n;
   int press_cyc, long_cyc;

   initial begin
      rst = 1'b1; tick_en = 1'b1; btn_db = 1'b1;

      // button held through reset, one low tick arms, then short press
      add(1, 1, 1, 6'b000000);
      add(1, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 0, 6'b000000);
      add(0, 1, 1, 6'b100001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 0, 6'b011000);
      add(0, 1, 0, 6'b000000);
      // press held 10 ticks: long on 4th, repeat on 6th/8th/10th
      add(0, 1, 1, 6'b100001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000101);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000011);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000011);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000011);
      add(0, 1, 0, 6'b010000);
      add(0, 1, 0, 6'b000000);
      // release on the 4th held tick: short, no long
      add(0, 1, 1, 6'b100001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 0, 6'b011000);
      add(0, 1, 0, 6'b000000);
      // tick_en low cycles ignore btn_db
      add(0, 0, 1, 6'b000000);
      add(0, 1, 1, 6'b100001);
      add(0, 0, 0, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 0, 0, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000101);
      // reset in LONG: silent, must see release before next press
      add(1, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 1, 6'b000000);
      add(0, 1, 0, 6'b000000);
      add(0, 1, 1, 6'b100001);
      add(0, 1, 0, 6'b011000);
      // release on the repeat threshold tick: no repeat
      add(0, 1, 1, 6'b100001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 1, 6'b000101);
      add(0, 1, 1, 6'b000001);
      add(0, 1, 0, 6'b010000);
      add(0, 1, 0, 6'b000000);

`ifdef BTN_REPEAT_EN
      mask = 6'b111111;
`else
      mask = 6'b111101;
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].te, vecs[i].btn);
         act = {press_o, release_o, short_o, long_o, repeat_w, held_o};
         checks++;
         if ((act & mask) !== (vecs[i].exp & mask)) begin
            failures++;
            $display("FAIL vec%0d {prs,rel,sht,lng,rep,hld}: got %b expected %b",
                     i, act & mask, vecs[i].exp & mask);
         end
      end

      // sparse ticks: one tick every 5 clocks, press held 4 ticks, then release
      step(1, 1, 1);
      step(1, 1, 1);
      press_n = 0; release_n = 0; short_n = 0; long_n = 0; repeat_n = 0; held_n = 0;
      press_cyc = -1; long_cyc = -1;
      for (int c = 0; c < 60; c++) begin
         step(1'b0, (c % 5) == 0, (c / 5 >= 1) && (c / 5 <= 5));
         if (press_o)   begin press_n++; press_cyc = c; end
         if (long_o)    begin long_n++;  long_cyc  = c; end
         if (release_o) release_n++;
         if (short_o)   short_n++;
         if (repeat_w)  repeat_n++;
         if (held_o)    held_n++;
      end
      check_int("sparse_press_width", press_n, 1);
      check_int("sparse_long_width", long_n, 1);
      check_int("sparse_press_to_long", long_cyc - press_cyc, 20);
      check_int("sparse_release_width", release_n, 1);
      check_int("sparse_short_count", short_n, 0);
      check_int("sparse_repeat_count", repeat_n, 0);
      check_int("sparse_held_cycles", held_n, 25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
